// File: rtl/sram_uart_tx.sv
// SRAM readback streamer: reads len bytes from base upward and sends each one on tx as an 8N1 frame.
// Optional macro SRAM_UART_TX_PARITY_EN adds an even-parity bit to each frame (8E1).
module sram_uart_tx #(
    parameter int CLKS_PER_BIT = 52,
    parameter int ADDR_W       = 17,
    parameter int RD_WAIT      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic [7:0]        data_i,
    output logic              ncs,
    output logic              noe,
    output logic              nwe,
    output logic [ADDR_W-1:0] addr,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        START,
        DATA,
`ifdef SRAM_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        FIN
    } state_t;

    localparam logic [15:0] BAUD_END = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  RD_END   = 4'(RD_WAIT - 1);
    localparam logic [3:0]  RD_GAP   = 4'(RD_WAIT);

    state_t            state_q, state_d;
    logic [15:0]       baud_q, baud_d;
    logic [2:0]        bitc_q, bitc_d;
    logic [3:0]        rdc_q, rdc_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [7:0]        sh_q, sh_d;
    logic [ADDR_W-1:0] addr_d;
    logic              tx_d, ncs_d, busy_d, done_d;
    logic              baud_end;

    assign nwe      = 1'b1;
    assign baud_end = (baud_q == BAUD_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bitc_q  <= '0;
            rdc_q   <= '0;
            rem_q   <= '0;
            sh_q    <= '0;
            addr    <= '0;
            tx      <= 1'b1;
            ncs     <= 1'b1;
            noe     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bitc_q  <= bitc_d;
            rdc_q   <= rdc_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            addr    <= addr_d;
            tx      <= tx_d;
            ncs     <= ncs_d;
            noe     <= ncs_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Outputs are computed for the state being entered, so they register in step with it.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bitc_d  = bitc_q;
        rdc_d   = rdc_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        addr_d  = addr;
        tx_d    = tx;
        ncs_d   = ncs;
        busy_d  = busy;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                ncs_d = 1'b1;
                // done still high means the transfer just ended; a start here is too early
                if (start && !done) begin
                    busy_d = 1'b1;
                    rem_d  = len;
                    if (len == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = READ;
                        addr_d  = base;
                        ncs_d   = 1'b0;
                        rdc_d   = '0;
                    end
                end
            end
            READ: begin
                rdc_d = rdc_q + 4'd1;
                if (rdc_q == RD_END) begin
                    sh_d  = data_i;
                    ncs_d = 1'b1;
                end
                if (rdc_q == RD_GAP) begin
                    rdc_d   = '0;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                baud_d = baud_q + 16'd1;
                if (baud_end) begin
                    baud_d  = '0;
                    bitc_d  = '0;
                    tx_d    = sh_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = baud_q + 16'd1;
                if (baud_end) begin
                    baud_d = '0;
                    bitc_d = bitc_q + 3'd1;
                    if (bitc_q == 3'd7) begin
`ifdef SRAM_UART_TX_PARITY_EN
                        tx_d    = ^sh_q;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        tx_d = sh_q[bitc_q + 3'd1];
                    end
                end
            end
`ifdef SRAM_UART_TX_PARITY_EN
            PARITY: begin
                baud_d = baud_q + 16'd1;
                if (baud_end) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                baud_d = baud_q + 16'd1;
                if (baud_end) begin
                    baud_d = '0;
                    rem_d  = rem_q - {{ADDR_W{1'b0}}, 1'b1};
                    if (rem_q == {{ADDR_W{1'b0}}, 1'b1}) begin
                        state_d = FIN;
                    end else begin
                        addr_d  = addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        ncs_d   = 1'b0;
                        rdc_d   = '0;
                        state_d = READ;
                    end
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_uart_tx.sv
// Directed bench for sram_uart_tx: SRAM model, independent UART receiver and hand-computed expectations.
module tb_sram_uart_tx;
    localparam int CPB = 4;
    localparam int AW  = 17;
    localparam int RDW = 2;
`ifdef SRAM_UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [0:NB-1] WSEQ = 11'b01010010101;
    localparam int BUSY1 = 48, BUSY3 = 142, BUSY2 = 95;
`else
    localparam int NB = 10;
    localparam logic [0:NB-1] WSEQ = 10'b0101001011;
    localparam int BUSY1 = 44, BUSY3 = 130, BUSY2 = 87;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic [7:0]    data_i;
    logic          ncs, noe, nwe, tx, busy, done;
    logic [AW-1:0] addr;

    sram_uart_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .RD_WAIT(RDW)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .len(len), .data_i(data_i),
        .ncs(ncs), .noe(noe), .nwe(nwe), .addr(addr), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:(1<<AW)-1];
    assign data_i = (!ncs && !noe) ? mem[addr] : 8'h00;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bus monitor: cumulative counters, sampled on the falling edge
    int busy_cnt = 0, done_cnt = 0, ncs_cnt = 0, mis_cnt = 0, txlow_cnt = 0, unst_cnt = 0;
    logic [AW-1:0] addrq[$];
    logic          txlog[$];
    initial begin
        logic          pncs;
        logic [AW-1:0] paddr;
        pncs  = 1'b1;
        paddr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pncs = 1'b1;
            end else begin
                busy_cnt  += int'(busy);
                done_cnt  += int'(done);
                ncs_cnt   += int'(!ncs);
                mis_cnt   += int'(ncs != noe);
                txlow_cnt += int'(!tx);
                if (!ncs && pncs) addrq.push_back(addr);
                if (!ncs && !pncs && addr != paddr) unst_cnt++;
                if (busy) txlog.push_back(tx);
                pncs  = ncs;
                paddr = addr;
            end
        end
    end

    // UART receiver, mid-bit sampling
    logic [7:0] rxq[$];
    logic       pq[$];
    logic       stq[$];
    initial begin
        logic [7:0] rb;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                repeat (CPB/2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    rb[i] = tx;
                end
`ifdef SRAM_UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                pq.push_back(tx);
`endif
                repeat (CPB) @(negedge clk);
                stq.push_back(tx);
                rxq.push_back(rb);
            end
        end
    end

    function automatic logic [63:0] rx_at(input int i);
        return (i < rxq.size()) ? {56'h0, rxq[i]} : 64'hFFFF;
    endfunction
    function automatic logic [63:0] ad_at(input int i);
        return (i < addrq.size()) ? 64'(addrq[i]) : 64'hFFFFF;
    endfunction
    function automatic logic [63:0] st_at(input int i);
        return (i < stq.size()) ? 64'(stq[i]) : 64'hF;
    endfunction

    int b0, d0, n0, m0, l0, u0, a0, t0, r0, p0;
    task automatic snap();
        b0 = busy_cnt; d0 = done_cnt; n0 = ncs_cnt; m0 = mis_cnt; l0 = txlow_cnt;
        u0 = unst_cnt; a0 = addrq.size(); t0 = txlog.size(); r0 = rxq.size(); p0 = pq.size();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [AW-1:0] b, input logic [AW:0] l);
        base  = b;
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
        tick();
    endtask

    logic [63:0] gw, ew;
    int nb;

    initial begin
        mem[17'h00010] = 8'hA5;
        mem[17'h00100] = 8'h01;
        mem[17'h00101] = 8'h80;
        mem[17'h00102] = 8'hFF;
        mem[17'h1FFFF] = 8'h3C;
        mem[17'h00000] = 8'hC3;
        mem[17'h00020] = 8'h5A;
        mem[17'h00030] = 8'h07;
        mem[17'h00031] = 8'h03;

        repeat (3) tick();
        chk("rst_tx", 64'(tx), 64'd1);
        chk("rst_ncs", 64'(ncs), 64'd1);
        chk("rst_noe", 64'(noe), 64'd1);
        chk("rst_nwe", 64'(nwe), 64'd1);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        repeat (2) tick();

        // single byte 0xA5 at 0x10
        snap();
        go(17'h00010, 18'd1);
        wait_done(300, "single");
        chk("single_busy_cycles", 64'(busy_cnt - b0), 64'(BUSY1));
        chk("single_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("single_ncs_low", 64'(ncs_cnt - n0), 64'd2);
        chk("single_ncs_noe_diff", 64'(mis_cnt - m0), 64'd0);
        chk("single_addr_unstable", 64'(unst_cnt - u0), 64'd0);
        chk("single_reads", 64'(addrq.size() - a0), 64'd1);
        chk("single_addr", ad_at(a0), 64'h10);
        chk("single_rx", rx_at(r0), 64'hA5);
        chk("single_stop", st_at(r0), 64'd1);
        nb = busy_cnt - b0;
        gw = '0;
        for (int i = 0; i < nb && i < 64 && (t0 + i) < txlog.size(); i++) gw = {gw[62:0], txlog[t0 + i]};
        ew = '0;
        repeat (3) ew = {ew[62:0], 1'b1};
        for (int k = 0; k < NB; k++) repeat (CPB) ew = {ew[62:0], WSEQ[k]};
        ew = {ew[62:0], 1'b1};
        chk("single_tx_wave", gw, ew);

        // three bytes, with a second start during the transfer
        snap();
        go(17'h00100, 18'd3);
        repeat (60) tick();
        go(17'h00000, 18'd5);
        wait_done(800, "multi");
        chk("multi_rxn", 64'(rxq.size() - r0), 64'd3);
        chk("multi_rx0", rx_at(r0), 64'h01);
        chk("multi_rx1", rx_at(r0 + 1), 64'h80);
        chk("multi_rx2", rx_at(r0 + 2), 64'hFF);
        chk("multi_reads", 64'(addrq.size() - a0), 64'd3);
        chk("multi_addr0", ad_at(a0), 64'h100);
        chk("multi_addr1", ad_at(a0 + 1), 64'h101);
        chk("multi_addr2", ad_at(a0 + 2), 64'h102);
        chk("multi_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("multi_busy_cycles", 64'(busy_cnt - b0), 64'(BUSY3));
        chk("multi_ncs_low", 64'(ncs_cnt - n0), 64'd6);

        // address wrap
        snap();
        go(17'h1FFFF, 18'd2);
        wait_done(600, "wrap");
        chk("wrap_addr0", ad_at(a0), 64'h1FFFF);
        chk("wrap_addr1", ad_at(a0 + 1), 64'h0);
        chk("wrap_rx0", rx_at(r0), 64'h3C);
        chk("wrap_rx1", rx_at(r0 + 1), 64'hC3);
        chk("wrap_busy_cycles", 64'(busy_cnt - b0), 64'(BUSY2));

        // zero length; start coincident with done
        snap();
        go(17'h00040, 18'd0);
        chk("zl_busy_rise", 64'(busy), 64'd1);
        chk("zl_done_early", 64'(done), 64'd0);
        tick();
        chk("zl_done", 64'(done), 64'd1);
        chk("zl_busy_fall", 64'(busy), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_on_done_ignored", 64'(busy), 64'd0);
        repeat (3) tick();
        chk("zl_still_idle", 64'(busy), 64'd0);
        chk("zl_ncs_low", 64'(ncs_cnt - n0), 64'd0);
        chk("zl_tx_low", 64'(txlow_cnt - l0), 64'd0);
        chk("zl_done_pulses", 64'(done_cnt - d0), 64'd1);

`ifdef SRAM_UART_TX_PARITY_EN
        snap();
        go(17'h00030, 18'd2);
        wait_done(600, "par");
        chk("par_rx0", rx_at(r0), 64'h07);
        chk("par_rx1", rx_at(r0 + 1), 64'h03);
        chk("par_bit0", (p0 < pq.size()) ? 64'(pq[p0]) : 64'hF, 64'd1);
        chk("par_bit1", (p0 + 1 < pq.size()) ? 64'(pq[p0 + 1]) : 64'hF, 64'd0);
        chk("par_stop1", st_at(r0 + 1), 64'd1);
        chk("par_busy_cycles", 64'(busy_cnt - b0), 64'(BUSY2));
`endif

        // reset during bit 2 of 0x5A (a zero bit)
        go(17'h00020, 18'd1);
        repeat (16) tick();
        chk("pre_rst_tx", 64'(tx), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tx", 64'(tx), 64'd1);
        chk("async_rst_ncs", 64'(ncs), 64'd1);
        chk("async_rst_noe", 64'(noe), 64'd1);
        chk("async_rst_busy", 64'(busy), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("post_rst_tx", 64'(tx), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_ncs", 64'(ncs), 64'd1);
        repeat (50) tick();
        snap();
        go(17'h00020, 18'd1);
        wait_done(300, "after_rst");
        chk("after_rst_rx", rx_at(r0), 64'h5A);
        chk("after_rst_rxn", 64'(rxq.size() - r0), 64'd1);
        chk("after_rst_busy_cycles", 64'(busy_cnt - b0), 64'(BUSY1));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
